// File: rtl/sig_framer.sv
// Source-side framer: samples WIDTH-antenna 1-bit I/Q radio streams and emits COUNT-sample frames
// through a 2-deep output buffer. Define SIG_FRAMER_TESTPAT_EN to replace pushed data with a counter pattern.
module sig_framer #(
    parameter int WIDTH   = 4,
    parameter int COUNT   = 150,
    parameter int NFRAMES = 0,
    parameter int FBITS   = 16
) (
    input  logic             sig_clock,
    input  logic             areset_n,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [WIDTH-1:0] radio_idata_i,
    input  logic [WIDTH-1:0] radio_qdata_i,
    output logic             sig_valid_o,
    input  logic             sig_ready_i,
    output logic             sig_last_o,
    output logic [WIDTH-1:0] sig_idata_o,
    output logic [WIDTH-1:0] sig_qdata_o,
    output logic             busy_o,
    output logic [FBITS-1:0] frames_o,
    output logic             overflow_o
);

    localparam int SCW = (COUNT > 1) ? $clog2(COUNT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] in_i;
    logic [WIDTH-1:0] in_q;
    logic [SCW-1:0]   scnt;
    logic [31:0]      run_frames;
    logic             stop_seen;

    logic             skid_valid;
    logic             skid_last;
    logic [WIDTH-1:0] skid_i;
    logic [WIDTH-1:0] skid_q;

    logic             push;
    logic             pop;
    logic             accept;
    logic             push_last;
    logic             run_done;
    logic [WIDTH-1:0] push_i;
    logic [WIDTH-1:0] push_q;

    assign push      = (state == RUN);
    assign pop       = sig_valid_o && sig_ready_i;
    // A push is lost only when both slots are occupied and nothing leaves this cycle.
    assign accept    = push && !(sig_valid_o && skid_valid && !pop);
    assign push_last = (scnt == SCW'(COUNT - 1));
    assign run_done  = (NFRAMES != 0) && ((run_frames + 32'd1) == 32'(NFRAMES));
    assign busy_o    = (state != IDLE) || sig_valid_o;

`ifdef SIG_FRAMER_TESTPAT_EN
    logic [31:0] scnt_ext;
    assign scnt_ext = 32'(scnt);
    assign push_i   = scnt_ext[WIDTH-1:0];
    assign push_q   = ~scnt_ext[WIDTH-1:0];
`else
    assign push_i = in_i;
    assign push_q = in_q;
`endif

    // NOTE: every clocked block uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge sig_clock or negedge areset_n) begin
        if (!areset_n) begin
            in_i <= '0;
            in_q <= '0;
        end else begin
            in_i <= radio_idata_i;
            in_q <= radio_qdata_i;
        end
    end

    always_ff @(posedge sig_clock or negedge areset_n) begin
        if (!areset_n) begin
            state      <= IDLE;
            scnt       <= '0;
            run_frames <= '0;
            stop_seen  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    scnt <= '0;
                    if (start_i) begin
                        state      <= RUN;
                        stop_seen  <= stop_i;
                        run_frames <= '0;
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        stop_seen <= 1'b1;
                    end
                    if (accept) begin
                        if (push_last) begin
                            scnt       <= '0;
                            run_frames <= run_frames + 32'd1;
                            if (stop_seen || stop_i || run_done) begin
                                state <= DRAIN;
                            end
                        end else begin
                            scnt <= scnt + SCW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!sig_valid_o && !skid_valid) begin
                        state     <= IDLE;
                        stop_seen <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sig_clock or negedge areset_n) begin
        if (!areset_n) begin
            sig_valid_o <= 1'b0;
            sig_last_o  <= 1'b0;
            sig_idata_o <= '0;
            sig_qdata_o <= '0;
            skid_valid  <= 1'b0;
            skid_last   <= 1'b0;
            skid_i      <= '0;
            skid_q      <= '0;
        end else if (pop) begin
            if (skid_valid) begin
                sig_last_o  <= skid_last;
                sig_idata_o <= skid_i;
                sig_qdata_o <= skid_q;
                if (accept) begin
                    skid_last <= push_last;
                    skid_i    <= push_i;
                    skid_q    <= push_q;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (accept) begin
                sig_last_o  <= push_last;
                sig_idata_o <= push_i;
                sig_qdata_o <= push_q;
            end else begin
                sig_valid_o <= 1'b0;
            end
        end else if (accept) begin
            if (!sig_valid_o) begin
                sig_valid_o <= 1'b1;
                sig_last_o  <= push_last;
                sig_idata_o <= push_i;
                sig_qdata_o <= push_q;
            end else begin
                skid_valid <= 1'b1;
                skid_last  <= push_last;
                skid_i     <= push_i;
                skid_q     <= push_q;
            end
        end
    end

    always_ff @(posedge sig_clock or negedge areset_n) begin
        if (!areset_n) begin
            frames_o   <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (pop && sig_last_o) begin
                frames_o <= frames_o + FBITS'(1);
            end
            if (push && !accept) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sig_framer.sv
// Randomized bench for sig_framer: a queue-based reference model tracks the expected output stream,
// plus a second NFRAMES=1 instance checked against the radio history.
module tb_sig_framer;

    localparam int COUNT = 150;

    logic       sig_clock = 1'b0;
    logic       areset_n  = 1'b0;
    logic       start = 1'b0, stop = 1'b0, ready = 1'b1;
    logic [3:0] radio_i = 4'h0, radio_q = 4'h0;
    logic       sig_valid, sig_last, busy, overflow;
    logic [3:0] sig_idata, sig_qdata;
    logic [1:0] frames;

    logic        nf_start = 1'b0, nf_stop = 1'b0, nf_ready = 1'b1;
    logic        nf_valid, nf_last, nf_busy, nf_overflow;
    logic [3:0]  nf_idata, nf_qdata;
    logic [15:0] nf_frames;

    int vectors = 0;
    int miscompares = 0;

    always #5 sig_clock = ~sig_clock;

    sig_framer #(.WIDTH(4), .COUNT(COUNT), .NFRAMES(0), .FBITS(2)) dut (
        .sig_clock(sig_clock), .areset_n(areset_n), .start_i(start), .stop_i(stop),
        .radio_idata_i(radio_i), .radio_qdata_i(radio_q), .sig_valid_o(sig_valid),
        .sig_ready_i(ready), .sig_last_o(sig_last), .sig_idata_o(sig_idata),
        .sig_qdata_o(sig_qdata), .busy_o(busy), .frames_o(frames), .overflow_o(overflow)
    );

    sig_framer #(.WIDTH(4), .COUNT(COUNT), .NFRAMES(1), .FBITS(16)) dut_nf (
        .sig_clock(sig_clock), .areset_n(areset_n), .start_i(nf_start), .stop_i(nf_stop),
        .radio_idata_i(radio_i), .radio_qdata_i(radio_q), .sig_valid_o(nf_valid),
        .sig_ready_i(nf_ready), .sig_last_o(nf_last), .sig_idata_o(nf_idata),
        .sig_qdata_o(nf_qdata), .busy_o(nf_busy), .frames_o(nf_frames), .overflow_o(nf_overflow)
    );

    // Reference model: a 2-entry queue fed by the framing rules, drained by ready.
    typedef struct packed {
        logic       last;
        logic [3:0] i;
        logic [3:0] q;
    } beat_t;

    beat_t      mq[$];
    beat_t      mb;
    bit         m_run, m_drain, m_stop, m_ovf, m_was_empty;
    int         m_idx, m_done;
    logic [1:0] m_frames;
    logic [3:0] m_in_i, m_in_q;
    logic [7:0] h1, h2;

    always @(posedge sig_clock or negedge areset_n) begin
        if (!areset_n) begin
            mq.delete();
            m_run = 0; m_drain = 0; m_stop = 0; m_ovf = 0;
            m_idx = 0; m_done = 0; m_frames = 0; m_in_i = 0; m_in_q = 0;
        end else begin
            m_was_empty = (mq.size() == 0);
            if (!m_was_empty && ready) begin
                if (mq[0].last) m_frames = m_frames + 2'd1;
                void'(mq.pop_front());
            end
            if (m_run) begin
                if (mq.size() < 2) begin
                    mb.last = (m_idx == COUNT - 1);
`ifdef SIG_FRAMER_TESTPAT_EN
                    mb.i = 4'(m_idx);
                    mb.q = ~4'(m_idx);
`else
                    mb.i = m_in_i;
                    mb.q = m_in_q;
`endif
                    mq.push_back(mb);
                    m_idx = mb.last ? 0 : m_idx + 1;
                    if (mb.last) begin
                        m_done++;
                        if (m_stop || stop) begin
                            m_run = 0;
                            m_drain = 1;
                        end
                    end
                end else begin
                    m_ovf = 1;
                end
                if (stop) m_stop = 1;
            end else if (m_drain) begin
                if (m_was_empty) begin
                    m_drain = 0;
                    m_stop = 0;
                end
            end else if (start) begin
                m_run = 1; m_stop = stop; m_done = 0; m_idx = 0;
            end
            m_in_i = radio_i;
            m_in_q = radio_q;
        end
    end

    always @(posedge sig_clock) begin
        h2 = h1;
        h1 = {radio_i, radio_q};
    end

    function automatic logic exp_valid();
        return mq.size() > 0;
    endfunction

    function automatic logic exp_busy();
        return m_run || m_drain || (mq.size() > 0);
    endfunction

    function automatic beat_t exp_beat();
        return (mq.size() > 0) ? mq[0] : beat_t'(9'h0);
    endfunction

    task automatic drive_radio();
        radio_i = 4'($urandom);
        radio_q = 4'($urandom);
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        repeat (3) @(negedge sig_clock);
        vectors++;
        if ({sig_valid, sig_last, sig_idata, sig_qdata, busy, frames, overflow} !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_main got %h exp 0", {sig_valid, sig_last, sig_idata, sig_qdata, busy, frames, overflow});
        end
        vectors++;
        if ({nf_valid, nf_last, nf_idata, nf_qdata, nf_busy, nf_frames, nf_overflow} !== 28'h0) begin
            miscompares++;
            $display("FAIL reset_nf got %h exp 0", {nf_valid, nf_last, nf_idata, nf_qdata, nf_busy, nf_frames, nf_overflow});
        end
        areset_n = 1'b1;
    endtask

    task automatic test_continuous_stop();
        int beats = 0, c = 0, first_c = -1, last_c = -1;
        int lasts[$];
        bit stopped = 0;
        start = 1; ready = 1;
        while (c < 1000) begin
            @(negedge sig_clock); c++;
            vectors++;
            if ({sig_valid, busy, overflow, frames} !== {exp_valid(), exp_busy(), m_ovf, m_frames}
                || (sig_valid && {sig_last, sig_idata, sig_qdata} !== exp_beat())) begin
                miscompares++;
                $display("FAIL cont_stream t=%0t got v=%b b=%b o=%b f=%0d beat=%h exp v=%b b=%b o=%b f=%0d beat=%h", $time,
                         sig_valid, busy, overflow, frames, {sig_last, sig_idata, sig_qdata},
                         exp_valid(), exp_busy(), m_ovf, m_frames, exp_beat());
            end
            if (beats > 0 && !busy) break;
            drive_radio();
            if (beats == 200 && !stopped) begin
                stop = 1; start = 0; stopped = 1;
            end else begin
                stop = 0;
            end
            if (sig_valid && ready) begin
                beats++;
                if (first_c < 0) first_c = c;
                last_c = c;
                if (sig_last) lasts.push_back(beats);
            end
        end
        vectors++;
        if (c >= 1000) begin miscompares++; $display("FAIL cont_timeout got %0d cycles exp <1000", c); end
        vectors++;
        if (beats != 300) begin miscompares++; $display("FAIL cont_beats got %0d exp 300", beats); end
        vectors++;
        if (lasts.size() != 2 || lasts[0] != 150 || lasts[1] != 300) begin
            miscompares++;
            $display("FAIL cont_lasts got %p exp '{150,300}", lasts);
        end
        vectors++;
        if (last_c - first_c != 299) begin miscompares++; $display("FAIL cont_gap got span %0d exp 299", last_c - first_c); end
        vectors++;
        if (frames !== 2'd2) begin miscompares++; $display("FAIL cont_frames got %0d exp 2", frames); end
    endtask

    task automatic test_ready_stall(input int stall_len, input bit exp_ovf, input logic [1:0] exp_frames, input string name);
        int beats = 0, c = 0, stall_left = 0;
        int lasts[$];
        bit stalled = 0;
        logic [9:0] held = '0;
        start = 1; stop = 1; ready = 1;
        while (c < 1000) begin
            @(negedge sig_clock); c++;
            vectors++;
            if ({sig_valid, busy, overflow, frames} !== {exp_valid(), exp_busy(), m_ovf, m_frames}
                || (sig_valid && {sig_last, sig_idata, sig_qdata} !== exp_beat())) begin
                miscompares++;
                $display("FAIL %s_stream t=%0t got v=%b b=%b o=%b f=%0d beat=%h exp v=%b b=%b o=%b f=%0d beat=%h", name, $time,
                         sig_valid, busy, overflow, frames, {sig_last, sig_idata, sig_qdata},
                         exp_valid(), exp_busy(), m_ovf, m_frames, exp_beat());
            end
            if (!ready && held[9]) begin
                vectors++;
                if ({sig_valid, sig_last, sig_idata, sig_qdata} !== held) begin
                    miscompares++;
                    $display("FAIL %s_hold got %h exp %h", name, {sig_valid, sig_last, sig_idata, sig_qdata}, held);
                end
            end
            if (beats > 0 && !busy) break;
            start = 0; stop = 0;
            drive_radio();
            if (beats == 60 && !stalled) begin
                stall_left = stall_len;
                stalled = 1;
            end
            ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            held = {sig_valid, sig_last, sig_idata, sig_qdata};
            if (sig_valid && ready) begin
                beats++;
                if (sig_last) lasts.push_back(beats);
            end
        end
        ready = 1;
        vectors++;
        if (c >= 1000) begin miscompares++; $display("FAIL %s_timeout got %0d cycles exp <1000", name, c); end
        vectors++;
        if (beats != 150) begin miscompares++; $display("FAIL %s_beats got %0d exp 150", name, beats); end
        vectors++;
        if (lasts.size() != 1 || lasts[0] != 150) begin miscompares++; $display("FAIL %s_lasts got %p exp '{150}", name, lasts); end
        vectors++;
        if (overflow !== exp_ovf) begin miscompares++; $display("FAIL %s_overflow got %b exp %b", name, overflow, exp_ovf); end
        vectors++;
        if (frames !== exp_frames) begin miscompares++; $display("FAIL %s_frames got %0d exp %0d", name, frames, exp_frames); end
    endtask

    task automatic test_random_ready();
        int beats = 0, c = 0;
        int lasts[$];
        bit stopped = 0;
        logic [9:0] held = '0;
        start = 1; ready = 1;
        while (c < 3000) begin
            @(negedge sig_clock); c++;
            vectors++;
            if ({sig_valid, busy, overflow, frames} !== {exp_valid(), exp_busy(), m_ovf, m_frames}
                || (sig_valid && {sig_last, sig_idata, sig_qdata} !== exp_beat())) begin
                miscompares++;
                $display("FAIL rand_stream t=%0t got v=%b b=%b o=%b f=%0d beat=%h exp v=%b b=%b o=%b f=%0d beat=%h", $time,
                         sig_valid, busy, overflow, frames, {sig_last, sig_idata, sig_qdata},
                         exp_valid(), exp_busy(), m_ovf, m_frames, exp_beat());
            end
            if (!ready && held[9]) begin
                vectors++;
                if ({sig_valid, sig_last, sig_idata, sig_qdata} !== held) begin
                    miscompares++;
                    $display("FAIL rand_hold got %h exp %h", {sig_valid, sig_last, sig_idata, sig_qdata}, held);
                end
            end
            if (beats > 0 && !busy) break;
            drive_radio();
            if (beats >= 170 && !stopped) begin
                stop = 1; start = 0; stopped = 1;
            end else begin
                stop = 0;
            end
            ready = ($urandom_range(0, 3) != 0);
            held = {sig_valid, sig_last, sig_idata, sig_qdata};
            if (sig_valid && ready) begin
                beats++;
                if (sig_last) lasts.push_back(beats);
            end
        end
        ready = 1;
        vectors++;
        if (c >= 3000) begin miscompares++; $display("FAIL rand_timeout got %0d cycles exp <3000", c); end
        vectors++;
        if (beats != 300) begin miscompares++; $display("FAIL rand_beats got %0d exp 300", beats); end
        vectors++;
        if (lasts.size() != 2 || lasts[0] != 150 || lasts[1] != 300) begin
            miscompares++;
            $display("FAIL rand_lasts got %p exp '{150,300}", lasts);
        end
        vectors++;
        if (frames !== 2'd2) begin miscompares++; $display("FAIL rand_frames got %0d exp 2", frames); end
    endtask

    task automatic test_reset_mid_frame();
        int beats = 0, c = 0;
        start = 1; stop = 1; ready = 1;
        while (c < 300 && beats < 75) begin
            @(negedge sig_clock); c++;
            start = 0; stop = 0;
            drive_radio();
            if (sig_valid && ready) beats++;
        end
        #2 areset_n = 1'b0;
        #1;
        vectors++;
        if ({sig_valid, sig_last, sig_idata, sig_qdata, busy, frames, overflow} !== 14'h0) begin
            miscompares++;
            $display("FAIL midrst_async got %h exp 0", {sig_valid, sig_last, sig_idata, sig_qdata, busy, frames, overflow});
        end
        @(negedge sig_clock);
        areset_n = 1'b1;
        start = 1; stop = 1;
        beats = 0; c = 0;
        while (c < 1000) begin
            @(negedge sig_clock); c++;
            vectors++;
            if ({sig_valid, busy, overflow, frames} !== {exp_valid(), exp_busy(), m_ovf, m_frames}
                || (sig_valid && {sig_last, sig_idata, sig_qdata} !== exp_beat())) begin
                miscompares++;
                $display("FAIL midrst_stream t=%0t got v=%b b=%b o=%b f=%0d beat=%h exp v=%b b=%b o=%b f=%0d beat=%h", $time,
                         sig_valid, busy, overflow, frames, {sig_last, sig_idata, sig_qdata},
                         exp_valid(), exp_busy(), m_ovf, m_frames, exp_beat());
            end
            if (beats == 149) begin
                vectors++;
                if (frames !== 2'd0) begin miscompares++; $display("FAIL midrst_frames_early got %0d exp 0", frames); end
            end
            if (beats > 0 && !busy) break;
            start = 0; stop = 0;
            drive_radio();
            if (sig_valid && ready) beats++;
        end
        vectors++;
        if (c >= 1000) begin miscompares++; $display("FAIL midrst_timeout got %0d cycles exp <1000", c); end
        vectors++;
        if (beats != 150) begin miscompares++; $display("FAIL midrst_beats got %0d exp 150", beats); end
        vectors++;
        if (frames !== 2'd1 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_final got frames=%0d ovf=%b exp frames=1 ovf=0", frames, overflow);
        end
    endtask

    task automatic test_nframes();
        int beats = 0, c = 0;
        logic [7:0] exp_d;
        nf_start = 1;
        while (c < 1000) begin
            @(negedge sig_clock); c++;
            if (nf_valid) begin
                beats++;
`ifdef SIG_FRAMER_TESTPAT_EN
                exp_d = {4'(beats - 1), ~4'(beats - 1)};
`else
                exp_d = h2;
`endif
                vectors++;
                if ({nf_last, nf_idata, nf_qdata} !== {(beats == COUNT), exp_d}) begin
                    miscompares++;
                    $display("FAIL nf_beat%0d got last=%b d=%h exp last=%b d=%h", beats,
                             nf_last, {nf_idata, nf_qdata}, (beats == COUNT), exp_d);
                end
            end
            if (beats > 0 && !nf_busy) break;
            nf_start = 0;
            drive_radio();
        end
        vectors++;
        if (c >= 1000) begin miscompares++; $display("FAIL nf_timeout got %0d cycles exp <1000", c); end
        vectors++;
        if (beats != COUNT) begin miscompares++; $display("FAIL nf_beats got %0d exp %0d", beats, COUNT); end
        vectors++;
        if (nf_frames !== 16'd1 || nf_overflow !== 1'b0 || nf_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL nf_final got frames=%0d ovf=%b busy=%b exp 1/0/0", nf_frames, nf_overflow, nf_busy);
        end
        repeat (5) @(negedge sig_clock);
        vectors++;
        if (nf_busy !== 1'b0 || nf_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL nf_idle got busy=%b valid=%b exp 0/0", nf_busy, nf_valid);
        end
    endtask

    initial begin
        test_reset();
        test_continuous_stop();
        test_ready_stall(1, 1'b0, 2'd3, "blip");
        test_ready_stall(3, 1'b1, 2'd0, "ovf");
        test_random_ready();
        test_reset_mid_frame();
        test_nframes();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
